// File: rtl/handshake_fifo.sv
// Two-handshake FIFO: a request/acknowledge write side run by a small FSM and a
// pulse-acknowledged read side delivering at most one word every two cycles.
module handshake_fifo #(
    parameter int data_width = 32,
    parameter int depth      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      req_l,
    input  logic                      ack_l,
    input  logic [data_width-1:0]     din,
    input  logic                      req_r,
    output logic                      ack_r,
    output logic [data_width-1:0]     dout,
    output logic [$clog2(depth):0]    occupancy,
    output logic                      full,
    output logic                      empty,
    output logic [31:0]               count_in,
    output logic [31:0]               count_out
);

    localparam int aw = $clog2(depth);
    localparam logic [aw:0] full_lvl = depth[aw:0];

    // Handshake semantics: the producer's word is taken at a rising edge where
    // req_l=1 and ack_l=1; the consumer sees one word per one-cycle ack_r pulse.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wr_state_t;

    wr_state_t             state;
    wr_state_t             state_next;
    logic [data_width-1:0] mem [depth];
    logic [aw-1:0]         wr_ptr;
    logic [aw-1:0]         rd_ptr;
    logic                  do_wr;
    logic                  do_rd;
    logic [aw:0]           occ_next;

    assign do_wr = (state == WAIT) && ack_l;
    // ack_r in the term enforces the one-word-per-two-cycles read rate.
    assign do_rd = req_r && !ack_r && !empty;

    always_comb begin
        occ_next   = occupancy + {{aw{1'b0}}, do_wr} - {{aw{1'b0}}, do_rd};
        state_next = state;
        if (state == IDLE || do_wr) begin
            state_next = (occ_next < full_lvl) ? WAIT : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req_l     <= 1'b0;
            ack_r     <= 1'b0;
            dout      <= '0;
            occupancy <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_in  <= '0;
            count_out <= '0;
        end else begin
            state     <= state_next;
            req_l     <= (state_next == WAIT);
            ack_r     <= do_rd;
            occupancy <= occ_next;
            full      <= (occ_next == full_lvl);
            empty     <= (occ_next == '0);
            if (do_wr) begin
                wr_ptr   <= wr_ptr + 1'b1;
                count_in <= count_in + 32'd1;
            end
            if (do_rd) begin
                dout      <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
                count_out <= count_out + 32'd1;
            end
        end
    end

    // Storage is left untouched by reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: tb/tb_handshake_fifo.sv
// Directed bench for handshake_fifo: reset, fill, drain, simultaneous access,
// reset mid-stream and a paced 5000-word stream against an expected queue.
module tb_handshake_fifo;

    logic        clk;
    logic        rst;
    logic        req_l;
    logic        ack_l;
    logic [31:0] din;
    logic        req_r;
    logic        ack_r;
    logic [31:0] dout;
    logic [2:0]  occupancy;
    logic        full;
    logic        empty;
    logic [31:0] count_in;
    logic [31:0] count_out;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    handshake_fifo #(.data_width(32), .depth(4)) dut (
        .clk(clk), .rst(rst), .req_l(req_l), .ack_l(ack_l), .din(din),
        .req_r(req_r), .ack_r(ack_r), .dout(dout), .occupancy(occupancy),
        .full(full), .empty(empty), .count_in(count_in), .count_out(count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Producer: waits (bounded) for req_l, then acknowledges for one edge.
    task automatic push(input logic [31:0] v);
        int w;
        w = 0;
        @(negedge clk);
        while (!req_l && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_l) check("push_req_l", {31'b0, req_l}, 32'd1);
        ack_l = 1'b1;
        din   = v;
        @(posedge clk);
        #1 ack_l = 1'b0;
    endtask

    // Consumer: raises req_r and waits (bounded) for the next ack_r pulse.
    task automatic pop_expect(input string tag, input logic [31:0] v, output int waited);
        waited = 0;
        req_r  = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (!ack_r && waited < 50);
        check({tag, "_ack"}, {31'b0, ack_r}, 32'd1);
        check({tag, "_dout"}, dout, v);
    endtask

    // Asserts reset between edges, checks the cleared outputs, then releases.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check({tag, "_req_l"}, {31'b0, req_l}, 32'd0);
        check({tag, "_ack_r"}, {31'b0, ack_r}, 32'd0);
        check({tag, "_dout"}, dout, 32'd0);
        check({tag, "_occ"}, {29'b0, occupancy}, 32'd0);
        check({tag, "_full"}, {31'b0, full}, 32'd0);
        check({tag, "_empty"}, {31'b0, empty}, 32'd1);
        check({tag, "_cin"}, count_in, 32'd0);
        check({tag, "_cout"}, count_out, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check({tag, "_rel_req0"}, {31'b0, req_l}, 32'd0);
        @(negedge clk);
        check({tag, "_rel_req1"}, {31'b0, req_l}, 32'd1);
    endtask

    initial begin
        int   w;
        int   got;
        logic saw_full;

        rst   = 1'b1;
        ack_l = 1'b0;
        din   = '0;
        req_r = 1'b0;

        do_reset("rst0");

        // Fill with no reader: four writes, then the write side goes idle.
        for (int i = 0; i < 4; i++) push(i);
        check("fill_occ", {29'b0, occupancy}, 32'd4);
        check("fill_full", {31'b0, full}, 32'd1);
        check("fill_empty", {31'b0, empty}, 32'd0);
        check("fill_req_l", {31'b0, req_l}, 32'd0);
        check("fill_cin", count_in, 32'd4);
        @(negedge clk);
        ack_l = 1'b1;
        din   = 32'd99;
        repeat (2) @(posedge clk);
        #1 ack_l = 1'b0;
        check("idle_ack_occ", {29'b0, occupancy}, 32'd4);
        check("idle_ack_cin", count_in, 32'd4);

        // Drain: pulses on alternate cycles, oldest first.
        for (int i = 0; i < 4; i++) begin
            pop_expect("drain", i, w);
            if (i > 0) check("drain_gap", w, 32'd2);
        end
        check("drain_empty", {31'b0, empty}, 32'd1);
        check("drain_cout", count_out, 32'd4);
        repeat (3) begin
            @(negedge clk);
            check("drain_idle_ack", {31'b0, ack_r}, 32'd0);
        end
        req_r = 1'b0;

        // Simultaneous write and read at occupancy 2.
        push(32'd10);
        push(32'd11);
        check("sim_pre_occ", {29'b0, occupancy}, 32'd2);
        @(negedge clk);
        ack_l = 1'b1;
        din   = 32'd12;
        req_r = 1'b1;
        @(posedge clk);
        #1;
        ack_l = 1'b0;
        req_r = 1'b0;
        check("sim_occ", {29'b0, occupancy}, 32'd2);
        check("sim_ack", {31'b0, ack_r}, 32'd1);
        check("sim_dout", dout, 32'd10);
        check("sim_cin", count_in, 32'd7);
        check("sim_cout", count_out, 32'd5);
        @(negedge clk);
        pop_expect("sim_rest", 32'd11, w);
        pop_expect("sim_rest", 32'd12, w);
        req_r = 1'b0;

        // Reset with three words stored; they must be discarded.
        push(32'd20);
        push(32'd21);
        push(32'd22);
        check("mid_occ", {29'b0, occupancy}, 32'd3);
        do_reset("mid");
        push(32'd77);
        pop_expect("mid_first", 32'd77, w);
        req_r = 1'b0;
        @(negedge clk);
        check("mid_after_occ", {29'b0, occupancy}, 32'd0);

        // Stream: producer paced at the reader's maximum rate.
        do_reset("pre_stream");
        got      = 0;
        saw_full = 1'b0;
        fork
            begin
                for (int i = 0; i < 5000; i++) begin
                    exp_q.push_back(i);
                    push(i);
                    @(posedge clk);
                end
            end
            begin
                req_r = 1'b1;
                for (int c = 0; c < 30000 && got < 5000; c++) begin
                    @(negedge clk);
                    if (full) saw_full = 1'b1;
                    if (ack_r) begin
                        if (exp_q.size() == 0) check("stream_extra", dout, 32'hffff_ffff);
                        else check("stream_dout", dout, exp_q.pop_front());
                        got++;
                    end
                end
                req_r = 1'b0;
            end
        join
        check("stream_got", got, 32'd5000);
        check("stream_left", exp_q.size(), 32'd0);
        check("stream_full", {31'b0, saw_full}, 32'd0);
        check("stream_cin", count_in, 32'd5000);
        check("stream_cout", count_out, 32'd5000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
